// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the fft stream driver: FSM state encoding and strobe helper.
package fft_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_GAP   = 3'd2,
        ST_START = 3'd3,
        ST_RECV  = 3'd4
    } state_t;

    // Wide all-ones constant; users slice off DATA_WIDTH/8 bits for tstrb (covers DATA_WIDTH up to 1024).
    localparam logic [127:0] STRB_ALL = '1;

endpackage

// File: rtl/fft_stream_driver_if.sv
// Stream signals between the driver and the fft accelerator, plus the accelerator start pulse.
interface fft_stream_driver_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      m00_axis_tvalid;
    logic [DATA_WIDTH-1:0]     m00_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb;
    logic                      m00_axis_tlast;
    logic                      m00_axis_tready;
    logic                      start;
    logic                      s00_axis_tvalid;
    logic [DATA_WIDTH-1:0]     s00_axis_tdata;
    logic                      s00_axis_tlast;
    logic                      s00_axis_tready;

    modport master (
        output m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, start, s00_axis_tready,
        input  m00_axis_tready, s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast
    );

    modport slave (
        input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast, start, s00_axis_tready,
        output m00_axis_tready, s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast
    );
endinterface

// File: rtl/fft_stream_driver_word_buffer.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one read port
// that is either combinational or registered (REG_READ).
module word_buffer #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 1,
    parameter bit REG_READ   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg_read
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata <= '0;
                end else begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_comb_read
            // Reads as zero while reset is held so both flavours share the same port list.
            assign rdata = rst_n ? mem[raddr] : '0;
        end
    endgenerate
endmodule

// File: rtl/fft_stream_driver.sv
// Hardware exerciser for the fft accelerator: streams a stored frame out, pulses start,
// then captures the returned stream into a readable result buffer.
//
// state   | meaning
// IDLE    | tx buffer writable, waiting for go
// SEND    | streaming txbuf[idx] with tvalid held until each handshake
// GAP     | one idle cycle after the last input word
// START   | one-cycle start pulse to the accelerator
// RECV    | accepting results until a tlast handshake
module fft_stream_driver
    import fft_stream_pkg::*;
#(
    parameter int SIZE       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  go,
    fft_stream_driver_if.master   axis,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   result_count
);
    localparam logic [ADDR_WIDTH-1:0]   LAST_IDX  = ADDR_WIDTH'(SIZE - 1);
    localparam logic [ADDR_WIDTH:0]     CNT_MAX   = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [DATA_WIDTH/8-1:0] STRB_FULL = STRB_ALL[DATA_WIDTH/8-1:0];

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic                  done_nxt, overflow_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  rx_we;
    logic                  tx_we;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state        <= ST_IDLE;
            idx          <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            result_count <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            done         <= done_nxt;
            overflow     <= overflow_nxt;
            result_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        done_nxt     = done;
        overflow_nxt = overflow;
        count_nxt    = result_count;
        rx_we        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt    = ST_SEND;
                    idx_nxt      = '0;
                    done_nxt     = 1'b0;
                    overflow_nxt = 1'b0;
                    count_nxt    = '0;
                end
            end
            ST_SEND: begin
                if (axis.m00_axis_tready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = ST_GAP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            ST_GAP:   state_nxt = ST_START;
            ST_START: state_nxt = ST_RECV;
            ST_RECV: begin
                if (axis.s00_axis_tvalid) begin
                    // Words past the buffer are dropped but still flag overflow.
                    if (result_count < CNT_MAX) begin
                        rx_we     = 1'b1;
                        count_nxt = result_count + 1'b1;
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                    if (axis.s00_axis_tlast) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tx_we                = load_en && (state == ST_IDLE);
    assign axis.m00_axis_tvalid = (state == ST_SEND);
    assign axis.m00_axis_tlast  = (state == ST_SEND) && (idx == LAST_IDX);
    assign axis.m00_axis_tstrb  = STRB_FULL;
    assign axis.start           = (state == ST_START);
    assign axis.s00_axis_tready = (state == ST_RECV);
    assign busy                 = (state != ST_IDLE);

    word_buffer #(
        .DEPTH      (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (1'b0)
    ) u_tx_buf (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .we    (tx_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (idx),
        .rdata (axis.m00_axis_tdata)
    );

    word_buffer #(
        .DEPTH      (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_READ   (1'b1)
    ) u_rx_buf (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .we    (rx_we),
        .waddr (result_count[ADDR_WIDTH-1:0]),
        .wdata (axis.s00_axis_tdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_fft_stream_driver.sv
// Directed plus randomized bench for fft_stream_driver; the bench plays the accelerator
// and predicts results from a queue-based model of the returned stream.
module tb_fft_stream_driver;
    localparam int SIZE = 2;
    localparam int DW   = 32;
    localparam int AW   = 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          go;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   result_count;

    always #5 clk = ~clk;

    fft_stream_driver_if #(.DATA_WIDTH(DW)) axis ();

    fft_stream_driver #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rstn),
        .load_en         (load_en),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .go              (go),
        .axis            (axis.master),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .result_count    (result_count)
    );

    int tests  = 0;
    int failed = 0;
    int start_cnt = 0;

    logic [DW-1:0] tx_word [SIZE];
    logic [DW-1:0] res_q [$];
    logic [DW-1:0] exp_rx [SIZE];
    int            exp_cnt;
    logic          exp_ovf;

    always @(negedge clk) if (axis.start) start_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        for (int i = 0; i < SIZE; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = tx_word[i];
            step();
        end
        load_en = 1'b0;
    endtask

    task automatic go_pulse(input bit with_load, input logic [DW-1:0] d);
        go = 1'b1;
        if (with_load) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_data = d;
            tx_word[0] = d;
        end
        step();
        go      = 1'b0;
        load_en = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 0,0,1,0,1 then 1, 2: random ready
    task automatic send_phase(input int mode);
        int            hs = 0;
        int            cyc = 0;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic          pl = 1'b0;
        bit            pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        while (hs < SIZE && cyc < 200) begin
            case (mode)
                0:       axis.m00_axis_tready = 1'b1;
                1:       axis.m00_axis_tready = (cyc < 5) ? pat[cyc] : 1'b1;
                default: axis.m00_axis_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            check("tx_valid", 64'(axis.m00_axis_tvalid), 64'd1);
            if (prev_stall) begin
                check("tx_hold_data", 64'(axis.m00_axis_tdata), 64'(pd));
                check("tx_hold_last", 64'(axis.m00_axis_tlast), 64'(pl));
            end
            if (axis.m00_axis_tvalid && axis.m00_axis_tready) begin
                check("tx_data", 64'(axis.m00_axis_tdata), 64'(tx_word[hs]));
                check("tx_last", 64'(axis.m00_axis_tlast), 64'(hs == SIZE - 1));
                hs++;
            end
            prev_stall = axis.m00_axis_tvalid && !axis.m00_axis_tready;
            pd = axis.m00_axis_tdata;
            pl = axis.m00_axis_tlast;
            step();
            cyc++;
        end
        check("tx_handshakes", 64'(hs), 64'(SIZE));
        axis.m00_axis_tready = 1'b0;
    endtask

    task automatic start_phase();
        @(negedge clk);
        check("gap_valid", 64'(axis.m00_axis_tvalid), 64'd0);
        check("gap_start", 64'(axis.start), 64'd0);
        check("gap_busy", 64'(busy), 64'd1);
        step();
        @(negedge clk);
        check("start_pulse", 64'(axis.start), 64'd1);
        check("start_ready", 64'(axis.s00_axis_tready), 64'd0);
        step();
        @(negedge clk);
        check("recv_start_low", 64'(axis.start), 64'd0);
        check("recv_ready", 64'(axis.s00_axis_tready), 64'd1);
        step();
    endtask

    task automatic recv_phase(input bit gaps, input bit poke);
        axis.s00_axis_tvalid = 1'b0;
        if (poke) begin
            // go and a buffer write while busy must both be ignored
            go        = 1'b1;
            load_en   = 1'b1;
            load_addr = '0;
            load_data = 32'hDEADBEEF;
            step();
            go      = 1'b0;
            load_en = 1'b0;
            @(negedge clk);
            check("poke_busy", 64'(busy), 64'd1);
            check("poke_ready", 64'(axis.s00_axis_tready), 64'd1);
            check("poke_valid", 64'(axis.m00_axis_tvalid), 64'd0);
            step();
        end
        for (int i = 0; i < res_q.size(); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                axis.s00_axis_tvalid = 1'b0;
                step();
            end
            axis.s00_axis_tvalid = 1'b1;
            axis.s00_axis_tdata  = res_q[i];
            axis.s00_axis_tlast  = (i == res_q.size() - 1);
            @(negedge clk);
            check("rx_ready", 64'(axis.s00_axis_tready), 64'd1);
            step();
        end
        axis.s00_axis_tvalid = 1'b0;
        axis.s00_axis_tlast  = 1'b0;

        exp_cnt = 0;
        exp_ovf = 1'b0;
        foreach (res_q[i]) begin
            if (exp_cnt < SIZE) begin
                exp_rx[exp_cnt] = res_q[i];
                exp_cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
        end

        @(negedge clk);
        check("rx_ready_drop", 64'(axis.s00_axis_tready), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_done", 64'(done), 64'd1);
        check("end_count", 64'(result_count), 64'(exp_cnt));
        check("end_overflow", 64'(overflow), 64'(exp_ovf));
        for (int a = 0; a < exp_cnt; a++) begin
            rd_addr = AW'(a);
            step();
            @(negedge clk);
            check("rd_data", 64'(rd_data), 64'(exp_rx[a]));
        end
        step();
    endtask

    task automatic run_txn(input int mode, input bit gaps, input bit poke,
                           input bit with_load, input logic [DW-1:0] d);
        int s0;
        s0 = start_cnt;
        go_pulse(with_load, d);
        send_phase(mode);
        start_phase();
        recv_phase(gaps, poke);
        check("start_once", 64'(start_cnt - s0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; go = 1'b0; rd_addr = '0;
        axis.m00_axis_tready = 1'b0;
        axis.s00_axis_tvalid = 1'b0;
        axis.s00_axis_tdata  = '0;
        axis.s00_axis_tlast  = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_tvalid", 64'(axis.m00_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(axis.m00_axis_tlast), 64'd0);
        check("rst_start", 64'(axis.start), 64'd0);
        check("rst_rx_ready", 64'(axis.s00_axis_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_count", 64'(result_count), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("tstrb", 64'(axis.m00_axis_tstrb), 64'hF);
        rstn = 1'b1;
        step();

        // basic echo
        tx_word[0] = 32'h40490FDB;
        tx_word[1] = 32'hC0490FDB;
        load_frame();
        res_q = '{tx_word[0], tx_word[1]};
        run_txn(0, 1'b0, 1'b0, 1'b0, '0);

        // backpressure on the send side
        run_txn(1, 1'b0, 1'b0, 1'b0, '0);

        // more results than the buffer holds
        res_q = '{32'h1, 32'h2, 32'h3};
        run_txn(0, 1'b0, 1'b0, 1'b0, '0);

        // short frame
        res_q = '{32'h42F6E979};
        run_txn(0, 1'b0, 1'b0, 1'b0, '0);

        // reset in the middle of SEND, after the first handshake
        tx_word[0] = $urandom;
        tx_word[1] = $urandom;
        load_frame();
        go_pulse(1'b0, '0);
        axis.m00_axis_tready = 1'b1;
        step();
        axis.m00_axis_tready = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        @(negedge clk);
        check("abort_tvalid", 64'(axis.m00_axis_tvalid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        step();
        res_q = '{tx_word[1], tx_word[0]};
        run_txn(0, 1'b0, 1'b0, 1'b0, '0);

        // load and go in one cycle; go/load during RECV ignored
        res_q = '{32'($urandom), 32'($urandom)};
        run_txn(0, 1'b0, 1'b1, 1'b1, 32'h12345678);

        // no reload: frame must be the one from before the ignored write, then random runs
        for (int r = 0; r < 4; r++) begin
            int n;
            if (r > 0) begin
                tx_word[0] = $urandom;
                tx_word[1] = $urandom;
                load_frame();
            end
            n = $urandom_range(1, 4);
            res_q.delete();
            for (int k = 0; k < n; k++) res_q.push_back(32'($urandom));
            run_txn(2, 1'b1, 1'b0, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
